// File: rtl/digit_scan_sequencer_pkg.sv
// Shared types and width helpers for the digit scan sequencer.
// Scan state enum plus address and counter width functions.
package digit_scan_sequencer_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int prescale, input int blank);
    int m;
    m = (prescale > blank) ? prescale : blank;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/digit_scan_sequencer_timebase.sv
// Scan timebase: BLANK/SHOW dwell counter and MSD-first digit index.
// Exposes strobes for SHOW entry, last SHOW cycle and frame wrap.
module scan_timebase
  import digit_scan_sequencer_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 2,
  parameter int AW           = addr_w(NUM_DIGITS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output scan_state_t   state,
  output logic [AW-1:0] idx,
  output logic          to_show,
  output logic          last_show,
  output logic          wrap
);

  localparam int CW = cnt_w(PRESCALE, BLANK_CYCLES);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_d;
  logic [AW-1:0] idx_d;
  scan_state_t   state_d;

  assign to_show   = en && (state == BLANK) &&
                     (cnt == CW'(BLANK_CYCLES - 1));
  assign last_show = en && (state == SHOW) &&
                     (cnt == CW'(PRESCALE - 1));
  assign wrap      = last_show && (idx == '0);

  // State, dwell counter and digit index registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BLANK;
      idx   <= AW'(NUM_DIGITS - 1);
      cnt   <= '0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
      cnt   <= cnt_d;
    end
  end

  // Next state: en low parks in BLANK with the index held
  always_comb begin
    state_d = state;
    idx_d   = idx;
    cnt_d   = cnt + CW'(1);
    unique case (1'b1)
      !en: begin
        state_d = BLANK;
        cnt_d   = '0;
      end
      to_show: begin
        state_d = SHOW;
        cnt_d   = '0;
      end
      last_show: begin
        state_d = BLANK;
        cnt_d   = '0;
        idx_d   = wrap ? AW'(NUM_DIGITS - 1)
                       : idx - AW'(1);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/digit_scan_sequencer.sv
// Scanned-display feeder: double-buffered code words, one decoder,
// ripple-blank chained across scan slots for leading-zero blanking.
module digit_scan_sequencer
  import digit_scan_sequencer_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int CODE_W       = 8,
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 2,
  localparam int AW          = addr_w(NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  lz_en,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [AW-1:0]         wr_addr,
  input  logic [CODE_W-1:0]     wr_data,
  input  logic                  wr_commit,
  output logic                  commit_pend,
  input  logic                  rbo_in,
  output logic [CODE_W-1:0]     code_out,
  output logic                  rbi_out,
  output logic                  bi_out,
  output logic [NUM_DIGITS-1:0] dig_sel,
  output logic                  frame_start
);

  scan_state_t   state;
  logic [AW-1:0] idx;
  logic          to_show;
  logic          last_show;
  logic          wrap;

  logic [CODE_W-1:0] active   [NUM_DIGITS];
  logic [CODE_W-1:0] shadow   [NUM_DIGITS];
  logic [CODE_W-1:0] shadow_d [NUM_DIGITS];

  logic wr_fire;
  logic commit_fire;
  logic rbo_q;

  scan_timebase #(
    .NUM_DIGITS  (NUM_DIGITS),
    .PRESCALE    (PRESCALE),
    .BLANK_CYCLES(BLANK_CYCLES),
    .AW          (AW)
  ) u_timebase (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .state    (state),
    .idx      (idx),
    .to_show  (to_show),
    .last_show(last_show),
    .wrap     (wrap)
  );

  assign wr_ready    = !commit_pend;
  assign wr_fire     = wr_valid && wr_ready &&
                       (int'(wr_addr) < NUM_DIGITS);
  assign commit_fire = wr_commit && wr_ready;

  assign dig_sel = (state == SHOW) ? (NUM_DIGITS'(1) << idx) : '0;
  assign bi_out  = (state == BLANK);

  // Shadow after this cycle's write, so a same-cycle commit includes it
  always_comb begin
    shadow_d = shadow;
    if (wr_fire) shadow_d[wr_addr] = wr_data;
  end

  // Buffers and commit: copy only at frame wrap, or at once when idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        active[i] <= '0;
        shadow[i] <= '0;
      end
      commit_pend <= 1'b0;
    end else begin
      shadow <= shadow_d;
      if (commit_fire && !en) begin
        active <= shadow_d;
      end else if (commit_pend && (wrap || !en)) begin
        active      <= shadow;
        commit_pend <= 1'b0;
      end else if (commit_fire) begin
        commit_pend <= 1'b1;
      end
    end
  end

  // Decoder drive: code/rbi launch on SHOW entry, rbi drops on exit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_out    <= '0;
      rbi_out     <= 1'b0;
      rbo_q       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= wrap;
      if (last_show) rbo_q <= rbo_in;
      unique case (1'b1)
        (!en || last_show): rbi_out <= 1'b0;
        to_show: begin
          code_out <= active[idx];
          if (idx == AW'(NUM_DIGITS - 1))
            rbi_out <= lz_en;
          else if (idx == '0)
            rbi_out <= 1'b0;
          else
            rbi_out <= rbo_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_digit_scan_sequencer.sv
// Bench for digit_scan_sequencer: vector table, directed corner
// sequences and random traffic against a frame-position model.
module tb_digit_scan_sequencer;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int P  = 4;
  localparam int B  = 2;
  localparam int S  = B + P;
  localparam int F  = N * S;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          lz_en;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic          wr_commit;
  logic          commit_pend;
  logic          rbo_in;
  logic [W-1:0]  code_out;
  logic          rbi_out;
  logic          bi_out;
  logic [N-1:0]  dig_sel;
  logic          frame_start;

  int n_checks = 0;
  int n_fail   = 0;

  // model state: position inside the frame plus buffers
  int       pos;
  bit       m_pend;
  bit       m_fs;
  bit       m_rbi;
  bit       m_last_rbo;
  logic [W-1:0] m_code;
  logic [W-1:0] m_act [N];
  logic [W-1:0] m_sh  [N];

  typedef struct {
    logic         en;
    logic [N-1:0] dsel;
    logic         bi;
    logic         fs;
  } vec_t;

  vec_t vecs [11];

  always #5 clk = ~clk;

  // decoder stand-in: blanks a zero digit when its rbi is set
  assign rbo_in = rbi_out && (code_out == '0) && (dig_sel != '0);

  digit_scan_sequencer #(
    .NUM_DIGITS  (N),
    .CODE_W      (W),
    .PRESCALE    (P),
    .BLANK_CYCLES(B)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .lz_en      (lz_en),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_commit  (wr_commit),
    .commit_pend(commit_pend),
    .rbo_in     (rbo_in),
    .code_out   (code_out),
    .rbi_out    (rbi_out),
    .bi_out     (bi_out),
    .dig_sel    (dig_sel),
    .frame_start(frame_start)
  );

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int digit_of(input int p);
    return N - 1 - p / S;
  endfunction

  function automatic bit show_of(input int p);
    return (p % S) >= B;
  endfunction

  task automatic model_reset();
    pos        = 0;
    m_pend     = 0;
    m_fs       = 0;
    m_rbi      = 0;
    m_last_rbo = 0;
    m_code     = '0;
    for (int i = 0; i < N; i++) begin
      m_act[i] = '0;
      m_sh[i]  = '0;
    end
  endtask

  // advance the model by one clock using the inputs just sampled
  task automatic model_step();
    bit ready;
    bit wr;
    bit cm;
    bit wrapping;
    int d;
    ready    = !m_pend;
    wr       = wr_valid && ready;
    cm       = wr_commit && ready;
    wrapping = en && (pos == F - 1);
    if (wr) m_sh[wr_addr] = wr_data;
    if (cm && !en) begin
      m_act = m_sh;
    end else if (m_pend && (wrapping || !en)) begin
      m_act  = m_sh;
      m_pend = 0;
    end else if (cm) begin
      m_pend = 1;
    end
    m_fs = wrapping;
    d    = digit_of(pos);
    if (!en) begin
      pos = (N - 1 - d) * S;
    end else begin
      if (pos % S == S - 1)
        m_last_rbo = m_rbi && (m_code == '0);
      pos = (pos + 1) % F;
      if (pos % S == B) begin
        d      = digit_of(pos);
        m_code = m_act[d];
        if (d == N - 1)  m_rbi = lz_en;
        else if (d == 0) m_rbi = 0;
        else             m_rbi = m_last_rbo;
      end
    end
  endtask

  task automatic compare_all();
    bit           sh;
    int           d;
    logic [N-1:0] exp_sel;
    sh      = show_of(pos);
    d       = digit_of(pos);
    exp_sel = sh ? (N'(1) << d) : '0;
    check("dig_sel", dig_sel, exp_sel);
    check("bi_out", bi_out, !sh);
    check("rbi_out", rbi_out, sh ? m_rbi : 1'b0);
    check("frame_start", frame_start, m_fs);
    check("commit_pend", commit_pend, m_pend);
    check("wr_ready", wr_ready, !m_pend);
    if (sh) check("code_out", code_out, m_code);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic check_reset_vals();
    check("rst_dig_sel", dig_sel, 0);
    check("rst_bi", bi_out, 1);
    check("rst_rbi", rbi_out, 0);
    check("rst_code", code_out, 0);
    check("rst_fs", frame_start, 0);
    check("rst_pend", commit_pend, 0);
    check("rst_ready", wr_ready, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_vals();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    compare_all();
  endtask

  task automatic wait_fs(input int budget);
    int i = 0;
    do begin
      tick();
      i++;
    end while (!frame_start && i < budget);
    check("frame_start_seen", frame_start, 1);
  endtask

  task automatic wait_sel(input logic [N-1:0] v, input int budget);
    int i = 0;
    do begin
      tick();
      i++;
    end while (dig_sel != v && i < budget);
    check("dig_sel_seen", dig_sel, v);
  endtask

  initial begin
    logic seen [N];

    vecs[0]  = '{1'b1, 4'b0000, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 4'b1000, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 4'b1000, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 4'b1000, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 4'b1000, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 4'b0000, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 4'b0000, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 4'b0100, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 4'b0000, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 4'b0000, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 4'b0100, 1'b0, 1'b0};

    rst       = 1'b1;
    en        = 1'b0;
    lz_en     = 1'b0;
    wr_valid  = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    wr_commit = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_reset_vals();
    @(negedge clk);
    rst = 1'b0;
    compare_all();

    // 1: basic scan timing from reset, incl. one en drop
    for (int k = 0; k < 11; k++) begin
      en = vecs[k].en;
      tick();
      check("vec_dig_sel", dig_sel, vecs[k].dsel);
      check("vec_bi", bi_out, vecs[k].bi);
      check("vec_fs", frame_start, vecs[k].fs);
    end
    en = 1'b1;
    for (int k = 0; k < F - 8; k++) tick();
    check("fs_cycle_24", frame_start, 1);
    for (int k = 0; k < F; k++) tick();
    check("fs_cycle_48", frame_start, 1);

    // 2: load 07,00,00,00 with commit on the last write
    for (int a = 0; a < N; a++) begin
      wr_valid  = 1'b1;
      wr_addr   = AW'(a);
      wr_data   = (a == 0) ? 8'h07 : 8'h00;
      wr_commit = (a == N - 1);
      tick();
    end
    wr_valid  = 1'b0;
    wr_commit = 1'b0;
    check("pend_after_commit", commit_pend, 1);
    wait_fs(2 * F);
    check("pend_cleared", commit_pend, 0);
    for (int k = 0; k < F; k++) begin
      tick();
      if (dig_sel == 4'b0001) check("d0_code", code_out, 8'h07);
    end

    // 3: leading-zero ripple over 0,0,0,7
    lz_en = 1'b1;
    for (int i = 0; i < N; i++) seen[i] = 1'bx;
    wait_fs(2 * F);
    for (int k = 0; k < F; k++) begin
      tick();
      for (int i = 0; i < N; i++)
        if (dig_sel[i]) seen[i] = rbi_out;
    end
    check("rbi_d3", seen[3], 1);
    check("rbi_d2", seen[2], 1);
    check("rbi_d1", seen[1], 1);
    check("rbi_d0", seen[0], 0);

    // 4: writes stall while a commit is pending
    wr_valid  = 1'b1;
    wr_addr   = 2'd2;
    wr_data   = 8'h05;
    wr_commit = 1'b1;
    tick();
    wr_commit = 1'b0;
    wr_addr   = 2'd1;
    wr_data   = 8'h09;
    tick();
    check("ready_low_pend", wr_ready, 0);
    wait_fs(2 * F);
    check("ready_after_fs", wr_ready, 1);
    tick();
    wr_valid  = 1'b0;
    wr_commit = 1'b1;
    tick();
    wr_commit = 1'b0;
    check("pend_second", commit_pend, 1);
    wait_fs(2 * F);
    for (int k = 0; k < F; k++) begin
      tick();
      if (dig_sel == 4'b0010) check("d1_code", code_out, 8'h09);
      if (dig_sel == 4'b0100) check("d2_code", code_out, 8'h05);
    end

    // 5: en drop mid-SHOW of digit 2
    wait_sel(4'b0100, 2 * F);
    tick();
    en = 1'b0;
    tick();
    check("en0_blank", dig_sel, 0);
    check("en0_bi", bi_out, 1);
    en = 1'b1;
    tick();
    check("resume_blank", dig_sel, 0);
    for (int k = 0; k < P; k++) begin
      tick();
      check("resume_show", dig_sel, 4'b0100);
    end
    tick();
    check("resume_done", dig_sel, 0);

    // 6: reset mid-SHOW drops a pending commit
    wr_valid  = 1'b1;
    wr_addr   = 2'd3;
    wr_data   = 8'h3C;
    wr_commit = 1'b1;
    tick();
    wr_valid  = 1'b0;
    wr_commit = 1'b0;
    check("pend_before_rst", commit_pend, 1);
    wait_sel(4'b0010, 2 * F);
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    compare_all();
    for (int k = 0; k < F + 2; k++) begin
      tick();
      if (dig_sel == 4'b1000) check("d3_after_rst", code_out, 0);
    end

    // random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      wr_valid  = ($urandom_range(0, 3) == 0);
      wr_addr   = AW'($urandom_range(0, N - 1));
      wr_data   = ($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom);
      wr_commit = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 49) == 0) en = !en;
      if ($urandom_range(0, 199) == 0) lz_en = !lz_en;
      if ($urandom_range(0, 999) == 0) do_reset();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
